// File: rtl/pipe_stage_reg_if.sv
// pipe_stage_reg_if: bundle between one pipeline stage and the stage register that follows it.
interface pipe_stage_reg_if #(
  parameter int DATA_W = 32,
  parameter int PAY_N  = 3,
  parameter int REG_W  = 5,
  parameter int TNEW_W = 3,
  parameter int EXC_W  = 5,
  parameter int WE_W   = 4
);
  logic                    stall_i, bubble_i, exc_flush_i, valid_i;
  logic [DATA_W-1:0]       pc_i;
  logic [PAY_N*DATA_W-1:0] payload_i;
  logic [WE_W-1:0]         we_i;
  logic                    memtoreg_i;
  logic [REG_W-1:0]        wreg_i;
  logic [TNEW_W-1:0]       tnew_i;
  logic                    delay_i, exc_i, loc_exc_i;
  logic [EXC_W-1:0]        exc_code_i, loc_code_i;
  logic                    valid_o;
  logic [DATA_W-1:0]       pc_o;
  logic [PAY_N*DATA_W-1:0] payload_o;
  logic [WE_W-1:0]         we_o;
  logic                    memtoreg_o;
  logic [REG_W-1:0]        wreg_o;
  logic [TNEW_W-1:0]       tnew_o;
  logic                    delay_o, exc_o;
  logic [EXC_W-1:0]        exc_code_o;
  modport master (
    output stall_i, bubble_i, exc_flush_i, valid_i, pc_i, payload_i, we_i, memtoreg_i,
           wreg_i, tnew_i, delay_i, exc_i, exc_code_i, loc_exc_i, loc_code_i,
    input  valid_o, pc_o, payload_o, we_o, memtoreg_o, wreg_o, tnew_o, delay_o, exc_o, exc_code_o
  );
  modport slave (
    input  stall_i, bubble_i, exc_flush_i, valid_i, pc_i, payload_i, we_i, memtoreg_i,
           wreg_i, tnew_i, delay_i, exc_i, exc_code_i, loc_exc_i, loc_code_i,
    output valid_o, pc_o, payload_o, we_o, memtoreg_o, wreg_o, tnew_o, delay_o, exc_o, exc_code_o
  );
endinterface

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: inter-stage pipeline register with stall, bubble, exception merge and flush.
module pipe_stage_reg #(
  parameter int                DATA_W     = 32,
  parameter int                PAY_N      = 3,
  parameter int                REG_W      = 5,
  parameter int                TNEW_W     = 3,
  parameter int                EXC_W      = 5,
  parameter int                WE_W       = 4,
  parameter int                DEC_TNEW   = 1,
  parameter logic [DATA_W-1:0] RESET_PC   = DATA_W'(32'h0000_3000),
  parameter logic [DATA_W-1:0] HANDLER_PC = DATA_W'(32'h0000_4180)
) (
  input logic             clk,
  input logic             reset,
  pipe_stage_reg_if.slave bus
);
  logic                    valid_q, valid_d, memtoreg_q, memtoreg_d;
  logic                    delay_q, delay_d, exc_q, exc_d;
  logic [DATA_W-1:0]       pc_q, pc_d;
  logic [PAY_N*DATA_W-1:0] payload_q, payload_d;
  logic [WE_W-1:0]         we_q, we_d;
  logic [REG_W-1:0]        wreg_q, wreg_d;
  logic [TNEW_W-1:0]       tnew_q, tnew_d, tnew_l;
  logic [EXC_W-1:0]        exc_code_q, exc_code_d;
  logic                    kill, exc_m, sup;
  // kill covers both an explicit bubble and an invalid instruction arriving on load
  always_comb begin
    kill       = bus.bubble_i || !bus.valid_i;
    exc_m      = bus.exc_i || bus.loc_exc_i;
    sup        = kill || exc_m;
    tnew_l     = (DEC_TNEW != 0 && bus.tnew_i != '0) ? bus.tnew_i - TNEW_W'(1) : bus.tnew_i;
    pc_d       = bus.exc_flush_i ? HANDLER_PC : bus.stall_i ? pc_q : bus.pc_i;
    delay_d    = bus.exc_flush_i ? 1'b0 : bus.stall_i ? delay_q : bus.delay_i;
    valid_d    = bus.exc_flush_i ? 1'b0 : bus.stall_i ? valid_q : !kill;
    payload_d  = bus.exc_flush_i ? '0 : bus.stall_i ? payload_q : kill ? '0 : bus.payload_i;
    memtoreg_d = bus.exc_flush_i ? 1'b0 : bus.stall_i ? memtoreg_q : !kill && bus.memtoreg_i;
    we_d       = bus.exc_flush_i ? '0 : bus.stall_i ? we_q : sup ? '0 : bus.we_i;
    wreg_d     = bus.exc_flush_i ? '0 : bus.stall_i ? wreg_q : sup ? '0 : bus.wreg_i;
    tnew_d     = bus.exc_flush_i ? '0 : bus.stall_i ? tnew_q : sup ? '0 : tnew_l;
    exc_d      = bus.exc_flush_i ? 1'b0 : bus.stall_i ? exc_q : !kill && exc_m;
    exc_code_d = bus.exc_flush_i ? '0 : bus.stall_i ? exc_code_q : kill ? '0 :
                 bus.exc_i ? bus.exc_code_i : bus.loc_exc_i ? bus.loc_code_i : '0;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q       <= RESET_PC;
      valid_q    <= 1'b0;
      payload_q  <= '0;
      we_q       <= '0;
      memtoreg_q <= 1'b0;
      wreg_q     <= '0;
      tnew_q     <= '0;
      delay_q    <= 1'b0;
      exc_q      <= 1'b0;
      exc_code_q <= '0;
    end else begin
      pc_q       <= pc_d;
      valid_q    <= valid_d;
      payload_q  <= payload_d;
      we_q       <= we_d;
      memtoreg_q <= memtoreg_d;
      wreg_q     <= wreg_d;
      tnew_q     <= tnew_d;
      delay_q    <= delay_d;
      exc_q      <= exc_d;
      exc_code_q <= exc_code_d;
    end
  end
  assign bus.pc_o       = pc_q;
  assign bus.valid_o    = valid_q;
  assign bus.payload_o  = payload_q;
  assign bus.we_o       = we_q;
  assign bus.memtoreg_o = memtoreg_q;
  assign bus.wreg_o     = wreg_q;
  assign bus.tnew_o     = tnew_q;
  assign bus.delay_o    = delay_q;
  assign bus.exc_o      = exc_q;
  assign bus.exc_code_o = exc_code_q;
endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: two instances (Tnew decrement on/off) checked each cycle against a priority-rule model.
module tb_pipe_stage_reg;
  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [95:0] pay;
    logic [3:0]  we;
    logic        mtr;
    logic [4:0]  wreg;
    logic [2:0]  tnew;
    logic        delay;
    logic        exc;
    logic [4:0]  code;
  } st_t;
  logic        clk, reset, stall, bubble, flush, valid, mtr, delay, exc, loc_exc;
  logic [31:0] pc;
  logic [95:0] pay;
  logic [3:0]  we;
  logic [4:0]  wreg, exc_code, loc_code;
  logic [2:0]  tnew;
  st_t         m [2];
  st_t         dut [2];
  st_t         tmp;
  bit          armed;
  int          ncmp, nfail;
  for (genvar g = 0; g < 2; g++) begin : u
    pipe_stage_reg_if bus ();
    st_t o;
    assign bus.stall_i     = stall;
    assign bus.bubble_i    = bubble;
    assign bus.exc_flush_i = flush;
    assign bus.valid_i     = valid;
    assign bus.pc_i        = pc;
    assign bus.payload_i   = pay;
    assign bus.we_i        = we;
    assign bus.memtoreg_i  = mtr;
    assign bus.wreg_i      = wreg;
    assign bus.tnew_i      = tnew;
    assign bus.delay_i     = delay;
    assign bus.exc_i       = exc;
    assign bus.exc_code_i  = exc_code;
    assign bus.loc_exc_i   = loc_exc;
    assign bus.loc_code_i  = loc_code;
    assign o = {bus.valid_o, bus.pc_o, bus.payload_o, bus.we_o, bus.memtoreg_o,
                bus.wreg_o, bus.tnew_o, bus.delay_o, bus.exc_o, bus.exc_code_o};
    pipe_stage_reg #(.DEC_TNEW(g == 0 ? 1 : 0)) dut_i (.clk(clk), .reset(reset), .bus(bus));
  end
  assign dut[0] = u[0].o;
  assign dut[1] = u[1].o;
  initial clk = 1'b0;
  always #5 clk = ~clk;
  function automatic st_t nxt(st_t q, bit dec);
    st_t n;
    bit  e;
    n = '0;
    e = exc || loc_exc;
    if (reset) n.pc = 32'h3000;
    else if (flush) n.pc = 32'h4180;
    else if (stall) n = q;
    else if (bubble || !valid) begin
      n.pc = pc;
      n.delay = delay;
    end else begin
      n.valid = 1'b1;
      n.pc    = pc;
      n.pay   = pay;
      n.mtr   = mtr;
      n.delay = delay;
      n.exc   = e;
      n.code  = exc ? exc_code : loc_exc ? loc_code : 5'd0;
      n.we    = e ? 4'd0 : we;
      n.wreg  = e ? 5'd0 : wreg;
      n.tnew  = e ? 3'd0 : (dec && tnew > 0) ? tnew - 3'd1 : tnew;
    end
    return n;
  endfunction
  task automatic chk(input string nm, input logic [191:0] a, input logic [191:0] e);
    ncmp++;
    if (a !== e) begin
      nfail++;
      $display("FAIL %s: got %0h want %0h", nm, a, e);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    m[0] = nxt(m[0], 1'b1);
    m[1] = nxt(m[1], 1'b0);
    if (reset) armed = 1'b1;
    #1;
    if (armed) begin
      chk("model_dec", dut[0], m[0]);
      chk("model_nodec", dut[1], m[1]);
    end
  endtask
  task automatic idle();
    {reset, stall, bubble, flush, mtr, delay, exc, loc_exc} = '0;
    valid = 1'b1;
    {pc, pay, we, wreg, exc_code, loc_code, tnew} = '0;
  endtask
  initial begin
    ncmp = 0;
    nfail = 0;
    armed = 1'b0;
    idle();
    reset = 1'b1;
    cyc();
    chk("rst_pc", dut[0].pc, 32'h3000);
    tmp = dut[0];
    tmp.pc = '0;
    chk("rst_zero", tmp, 0);
    idle();
    pc = 32'h3004; tnew = 3'd2; wreg = 5'd8;
    cyc();
    chk("load_pc", dut[0].pc, 32'h3004);
    chk("load_tnew", dut[0].tnew, 1);
    chk("load_wreg", dut[0].wreg, 8);
    chk("load_valid", dut[0].valid, 1);
    chk("load_tnew_nodec", dut[1].tnew, 2);
    tnew = 3'd0;
    cyc();
    chk("tnew0_dec", dut[0].tnew, 0);
    chk("tnew0_nodec", dut[1].tnew, 0);
    tnew = 3'd3;
    cyc();
    chk("tnew3_dec", dut[0].tnew, 2);
    chk("tnew3_nodec", dut[1].tnew, 3);
    pc = 32'h3008; wreg = 5'd9;
    cyc();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      pc = $urandom; wreg = 5'($urandom); tnew = 3'($urandom); pay = {$urandom, $urandom, $urandom};
      cyc();
      chk("stall_pc", dut[0].pc, 32'h3008);
      chk("stall_wreg", dut[0].wreg, 9);
      chk("stall_tnew", dut[0].tnew, 2);
    end
    stall = 1'b0; pc = 32'h300c; wreg = 5'd10;
    cyc();
    chk("release_pc", dut[0].pc, 32'h300c);
    bubble = 1'b1; pc = 32'h3010; delay = 1'b1; we = 4'hf; wreg = 5'd7;
    cyc();
    chk("bub_pc", dut[0].pc, 32'h3010);
    chk("bub_delay", dut[0].delay, 1);
    chk("bub_we", dut[0].we, 0);
    chk("bub_wreg", dut[0].wreg, 0);
    chk("bub_valid", dut[0].valid, 0);
    idle();
    pc = 32'h3014; exc = 1'b1; exc_code = 5'd4; loc_exc = 1'b1; loc_code = 5'd12;
    we = 4'hf; wreg = 5'd3; tnew = 3'd2;
    cyc();
    chk("exc_up_code", dut[0].code, 4);
    chk("exc_up_flag", dut[0].exc, 1);
    chk("exc_up_we", dut[0].we, 0);
    exc = 1'b0;
    cyc();
    chk("exc_loc_code", dut[0].code, 12);
    chk("exc_loc_we", dut[0].we, 0);
    chk("exc_loc_wreg", dut[0].wreg, 0);
    chk("exc_loc_pc", dut[0].pc, 32'h3014);
    chk("exc_loc_tnew", dut[0].tnew, 0);
    idle();
    flush = 1'b1; stall = 1'b1; bubble = 1'b1; pc = 32'h3018; delay = 1'b1; wreg = 5'd5;
    cyc();
    chk("flush_pc", dut[0].pc, 32'h4180);
    tmp = dut[0];
    tmp.pc = '0;
    chk("flush_zero", tmp, 0);
    reset = 1'b1;
    cyc();
    chk("rst_over_flush_pc", dut[0].pc, 32'h3000);
    for (int i = 0; i < 600; i++) begin
      reset    = ($urandom % 40) == 0;
      flush    = ($urandom % 13) == 0;
      stall    = ($urandom % 4) == 0;
      bubble   = ($urandom % 5) == 0;
      valid    = ($urandom % 6) != 0;
      exc      = ($urandom % 5) == 0;
      loc_exc  = ($urandom % 5) == 0;
      mtr      = 1'($urandom);
      delay    = 1'($urandom);
      pc       = $urandom;
      pay      = {$urandom, $urandom, $urandom};
      we       = 4'($urandom);
      wreg     = 5'($urandom);
      tnew     = 3'($urandom);
      exc_code = 5'($urandom);
      loc_code = 5'($urandom);
      cyc();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Parametrised inter-stage pipeline register for the 5-stage MIPS core, replacing the per-stage hand-written registers (ID/EX, EX/MEM, MEM/WB).
- Carries PC, a generic payload bundle, write-enable masks, destination register and Tnew.
- Adds stall hold, bubble insertion that preserves PC and delay-slot information, exception merging with write suppression, a valid bit, and exception-flush to the handler PC.

Parameters:
- DATA_W, 32, width of PC and of each payload word
- PAY_N, 3, number of DATA_W payload words (e.g. ALU result, RD2, forwarded data)
- REG_W, 5, destination register index width
- TNEW_W, 3, Tnew counter width
- EXC_W, 5, ExcCode width
- WE_W, 4, memory byte-write-enable mask width
- DEC_TNEW, 1, if 1 Tnew decrements by 1 (saturating at 0) on each load; if 0 it is copied unchanged
- RESET_PC, 32'h0000_3000, PC output after reset
- HANDLER_PC, 32'h0000_4180, PC output after exception flush

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- stall_i  in  1  hold all outputs
- bubble_i  in  1  insert a nop while keeping PC and delay flag
- exc_flush_i  in  1  exception or eret flush, highest priority after reset
- valid_i  in  1  incoming instruction is real (not a bubble)
- pc_i  in  DATA_W  incoming PC
- payload_i  in  PAY_N*DATA_W  packed payload, word k at bits [k*DATA_W +: DATA_W]
- we_i  in  WE_W  memory byte write enables
- memtoreg_i  in  1  load-result select
- wreg_i  in  REG_W  destination register, 0 = none
- tnew_i  in  TNEW_W  cycles until result available
- delay_i  in  1  instruction is in a delay slot
- exc_i  in  1  exception already raised upstream
- exc_code_i  in  EXC_W  upstream ExcCode
- loc_exc_i  in  1  exception detected in this stage
- loc_code_i  in  EXC_W  local ExcCode
- valid_o, pc_o, payload_o, we_o, memtoreg_o, wreg_o, tnew_o, delay_o, exc_o, exc_code_o  out  matching widths  registered copies

Behaviour:
- All updates occur on posedge clk. Outputs are registers only, with no combinational path from input to output. Latency is 1 cycle.
- Priority order, exactly one branch per cycle: reset > exc_flush_i > stall_i > bubble_i > load.
- reset: pc_o = RESET_PC; every other output = 0.
- exc_flush_i: pc_o = HANDLER_PC; every other output = 0, including delay_o and valid_o.
- stall_i: every output holds its value, including tnew_o (no decrement while held).
- bubble_i:
  - pc_o = pc_i, delay_o = delay_i.
  - valid_o, we_o, memtoreg_o, wreg_o, tnew_o, exc_o, exc_code_o and payload_o are all 0.
- load:
  - All fields copy from their inputs.
  - tnew_o = (DEC_TNEW && tnew_i != 0) ? tnew_i - 1 : tnew_i.
  - Exception merge: exc_o = exc_i | loc_exc_i. exc_code_o = exc_i ? exc_code_i : (loc_exc_i ? loc_code_i : 0). The upstream (older) exception wins.
  - Write suppression: when the merged exception is set, we_o = 0, wreg_o = 0 and tnew_o = 0. pc_o, delay_o and payload_o still load, so CP0 sees EPC and BD.
  - valid_i = 0 on load behaves exactly as a bubble.
- Tnew arithmetic is unsigned at TNEW_W bits and never wraps below 0.
- A reset asserted mid-stall or mid-bubble overrides on that edge; there is no residual state.

Test Plan:
- Reset → pc_o = 0x3000; all other outputs 0. Then load with pc_i = 0x3004, tnew_i = 2, wreg_i = 8 → next cycle pc_o = 0x3004, tnew_o = 1, wreg_o = 8, valid_o = 1.
- Load tnew_i = 0 with DEC_TNEW = 1 → tnew_o = 0 (no wrap). Same stimulus with DEC_TNEW = 0 and tnew_i = 3 → tnew_o = 3.
- stall_i held for 3 cycles while inputs change → outputs frozen at prior values for all 3 cycles. Release → new inputs appear after 1 cycle.
- bubble_i with pc_i = 0x3010, delay_i = 1, we_i = 4'hF → pc_o = 0x3010, delay_o = 1, we_o = 0, wreg_o = 0, valid_o = 0.
- Exception merge:
  - exc_i = 1, code 4, with loc_exc_i = 1, code 12 → exc_code_o = 4.
  - exc_i = 0, loc_exc_i = 1, code 12 → exc_code_o = 12, with we_o = 0, wreg_o = 0 and pc_o = pc_i.
- exc_flush_i together with stall_i and bubble_i → pc_o = 0x4180, all else 0. A simultaneous reset instead gives pc_o = 0x3000.
